// File: rtl/term_pkg.sv
// Shared types and constants for the terminal cursor controller.
package term_pkg;

   localparam int unsigned DEF_COLS = 80;
   localparam int unsigned DEF_ROWS = 25;

   // Decoded escape commands. Uname sits above the 4-bit port range and
   // behaves exactly like none.
   typedef enum logic [4:0] {
      CMD_NONE   = 5'd0,
      CMD_DELETE = 5'd1,
      CMD_CUF    = 5'd2,
      CMD_CUB    = 5'd3,
      CMD_CNL    = 5'd4,
      CMD_CPL    = 5'd5,
      CMD_CHA    = 5'd6,
      CMD_CUP    = 5'd7,
      CMD_ED     = 5'd8,
      CMD_EL     = 5'd9,
      CMD_SU     = 5'd10,
      CMD_SD     = 5'd11,
      CMD_HVP    = 5'd12,
      CMD_SCP    = 5'd13,
      CMD_RCP    = 5'd14,
      CMD_CLEAR  = 5'd15,
      CMD_UNAME  = 5'd16
   } cmd_e;

   // Erase modes carried in p1 for ED / EL.
   localparam logic [7:0] FM_TO_END = 8'd0;
   localparam logic [7:0] FM_TO_CUR = 8'd1;
   localparam logic [7:0] FM_ALL    = 8'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_FILL
   } state_e;

endpackage

// File: rtl/term_cursor_ctrl_fill_seq.sv
// Blank-fill sequencer: walks a logical linear cell range one cell per
// cycle, tracking column, logical row and physical row with counters.
module term_fill_seq
   import term_pkg::*;
#(
   parameter int unsigned COLS = DEF_COLS,
   parameter int unsigned ROWS = DEF_ROWS,
   parameter int unsigned CW   = 7,
   parameter int unsigned RW   = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [RW-1:0] s_row,
   input  logic [CW-1:0] s_col,
   input  logic [RW-1:0] e_row,
   input  logic [CW-1:0] e_col,
   input  logic [RW-1:0] top_row,
   output logic          wr_en,
   output logic [RW-1:0] wr_row,
   output logic [CW-1:0] wr_col,
   output logic          done
);

   localparam logic [RW:0]   ROWS_X  = (RW+1)'(ROWS);
   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS-1);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS-1);

   logic          active;
   logic [RW-1:0] lrow, prow, er;
   logic [CW-1:0] col, ec;
   logic [RW:0]   psum;
   logic [RW-1:0] pstart;
   logic          last;

   // Physical start row: (logical + top) mod ROWS by compare-and-subtract.
   always_comb begin
      psum   = {1'b0, s_row} + {1'b0, top_row};
      pstart = (psum >= ROWS_X) ? RW'(psum - ROWS_X) : RW'(psum);
      last   = (lrow == er) && (col == ec);
   end

   // Range walker: column counter rolls into logical and physical rows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         lrow   <= '0;
         prow   <= '0;
         col    <= '0;
         er     <= '0;
         ec     <= '0;
      end else if (start) begin
         active <= 1'b1;
         lrow   <= s_row;
         prow   <= pstart;
         col    <= s_col;
         er     <= e_row;
         ec     <= e_col;
      end else if (active) begin
         if (last) begin
            active <= 1'b0;
         end else if (col == COL_MAX) begin
            col  <= '0;
            lrow <= lrow + RW'(1);
            prow <= (prow == ROW_MAX) ? '0 : prow + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   assign wr_en  = active;
   assign wr_row = prow;
   assign wr_col = col;
   assign done   = active && last;

endmodule

// File: rtl/term_cursor_ctrl.sv
// Terminal cursor controller: executes decoded escape commands against the
// cursor registers and drives blank fills into the frame buffer.
module term_cursor_ctrl
   import term_pkg::*;
#(
   parameter int unsigned COLS  = DEF_COLS,
   parameter int unsigned ROWS  = DEF_ROWS,
   parameter int unsigned CW    = 7,
   parameter int unsigned RW    = 5,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [3:0]    cmd_code,
   input  logic [7:0]    cmd_p1,
   input  logic [7:0]    cmd_p2,
   output logic [RW-1:0] cur_row,
   output logic [CW-1:0] cur_col,
   output logic [RW-1:0] top_row,
   output logic          wr_en,
   output logic [RW-1:0] wr_row,
   output logic [CW-1:0] wr_col,
   output logic [7:0]    wr_char,
   output logic          busy
);

   localparam logic [8:0]    ROWS9   = 9'(ROWS);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS-1);
   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS-1);

   state_e        state, state_nxt;
   cmd_e          code_q;
   logic [7:0]    p1_q, p2_q;
   logic [RW-1:0] sav_row;
   logic [CW-1:0] sav_col;

   logic [RW-1:0] row_nxt, top_nxt, fs_row, fe_row;
   logic [CW-1:0] col_nxt, fs_col, fe_col;
   logic          sav_en, fill_go, fill_start, fill_done;
   logic [8:0]    n1, n2, nr, t;

   // Command execution: cursor/top results and fill range for the EXEC cycle.
   always_comb begin
      n1      = (p1_q == 8'd0) ? 9'd1 : {1'b0, p1_q};
      n2      = (p2_q == 8'd0) ? 9'd1 : {1'b0, p2_q};
      nr      = (n1 > ROWS9) ? ROWS9 : n1;
      t       = '0;
      row_nxt = cur_row;
      col_nxt = cur_col;
      top_nxt = top_row;
      sav_en  = 1'b0;
      fill_go = 1'b0;
      fs_row  = cur_row;
      fs_col  = cur_col;
      fe_row  = cur_row;
      fe_col  = cur_col;
      case (code_q)
         CMD_CUF: begin
            t       = 9'(cur_col) + n1;
            col_nxt = (t > 9'(COL_MAX)) ? COL_MAX : CW'(t);
         end
         CMD_CUB: col_nxt = (n1 > 9'(cur_col)) ? '0 : CW'(9'(cur_col) - n1);
         CMD_CNL: begin
            t       = 9'(cur_row) + n1;
            row_nxt = (t > 9'(ROW_MAX)) ? ROW_MAX : RW'(t);
            col_nxt = '0;
         end
         CMD_CPL: begin
            row_nxt = (n1 > 9'(cur_row)) ? '0 : RW'(9'(cur_row) - n1);
            col_nxt = '0;
         end
         CMD_CHA: col_nxt = ((n1 - 9'd1) > 9'(COL_MAX)) ? COL_MAX : CW'(n1 - 9'd1);
         CMD_CUP, CMD_HVP: begin
            row_nxt = ((n1 - 9'd1) > 9'(ROW_MAX)) ? ROW_MAX : RW'(n1 - 9'd1);
            col_nxt = ((n2 - 9'd1) > 9'(COL_MAX)) ? COL_MAX : CW'(n2 - 9'd1);
         end
         CMD_SCP: sav_en = 1'b1;
         CMD_RCP: begin
            row_nxt = sav_row;
            col_nxt = sav_col;
         end
         CMD_DELETE: begin
            col_nxt = (cur_col == '0) ? '0 : cur_col - CW'(1);
            fill_go = 1'b1;
            fs_col  = col_nxt;
            fe_col  = col_nxt;
         end
         CMD_ED: begin
            case (p1_q)
               FM_TO_END: begin
                  fill_go = 1'b1;
                  fe_row  = ROW_MAX;
                  fe_col  = COL_MAX;
               end
               FM_TO_CUR: begin
                  fill_go = 1'b1;
                  fs_row  = '0;
                  fs_col  = '0;
               end
               FM_ALL: begin
                  fill_go = 1'b1;
                  fs_row  = '0;
                  fs_col  = '0;
                  fe_row  = ROW_MAX;
                  fe_col  = COL_MAX;
               end
               default: ;
            endcase
         end
         CMD_EL: begin
            case (p1_q)
               FM_TO_END: begin
                  fill_go = 1'b1;
                  fe_col  = COL_MAX;
               end
               FM_TO_CUR: begin
                  fill_go = 1'b1;
                  fs_col  = '0;
               end
               FM_ALL: begin
                  fill_go = 1'b1;
                  fs_col  = '0;
                  fe_col  = COL_MAX;
               end
               default: ;
            endcase
         end
         CMD_CLEAR: begin
            fill_go = 1'b1;
            fs_row  = '0;
            fs_col  = '0;
            fe_row  = ROW_MAX;
            fe_col  = COL_MAX;
            row_nxt = '0;
            col_nxt = '0;
         end
         CMD_SU: begin
            t       = 9'(top_row) + nr;
            top_nxt = (t >= ROWS9) ? RW'(t - ROWS9) : RW'(t);
            fill_go = 1'b1;
            fs_row  = RW'(ROWS9 - nr);
            fs_col  = '0;
            fe_row  = ROW_MAX;
            fe_col  = COL_MAX;
         end
         CMD_SD: begin
            t       = (9'(top_row) >= nr) ? 9'(top_row) - nr : 9'(top_row) + ROWS9 - nr;
            top_nxt = RW'(t);
            fill_go = 1'b1;
            fs_row  = '0;
            fs_col  = '0;
            fe_row  = RW'(nr - 9'd1);
            fe_col  = COL_MAX;
         end
         default: ;
      endcase
   end

   // Next-state logic: EXEC is always one cycle, FILL ends on the last write.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (cmd_valid) state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = fill_go ? ST_FILL : ST_IDLE;
         ST_FILL: if (fill_done) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Command latch and cursor/scroll registers, committed at the end of EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q  <= CMD_NONE;
         p1_q    <= '0;
         p2_q    <= '0;
         cur_row <= '0;
         cur_col <= '0;
         top_row <= '0;
         sav_row <= '0;
         sav_col <= '0;
      end else if (state == ST_IDLE) begin
         if (cmd_valid) begin
            code_q <= cmd_e'({1'b0, cmd_code});
            p1_q   <= cmd_p1;
            p2_q   <= cmd_p2;
         end
      end else if (state == ST_EXEC) begin
         cur_row <= row_nxt;
         cur_col <= col_nxt;
         top_row <= top_nxt;
         if (sav_en) begin
            sav_row <= cur_row;
            sav_col <= cur_col;
         end
      end
   end

   // The sequencer maps rows through the post-scroll top so SU/SD fills
   // land on the rows that just scrolled into view.
   assign fill_start = (state == ST_EXEC) && fill_go;

   term_fill_seq #(
      .COLS (COLS),
      .ROWS (ROWS),
      .CW   (CW),
      .RW   (RW)
   ) u_fill (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (fill_start),
      .s_row   (fs_row),
      .s_col   (fs_col),
      .e_row   (fe_row),
      .e_col   (fe_col),
      .top_row (top_nxt),
      .wr_en   (wr_en),
      .wr_row  (wr_row),
      .wr_col  (wr_col),
      .done    (fill_done)
   );

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign wr_char   = BLANK;

endmodule

// File: tb/tb_term_cursor_ctrl.sv
// Scoreboard bench for term_cursor_ctrl: the driver queues expected writes
// and per-command completion results; a negedge monitor pops and compares.
module tb_term_cursor_ctrl;
   import term_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_code = '0;
   logic [7:0] cmd_p1 = '0;
   logic [7:0] cmd_p2 = '0;
   logic [4:0] cur_row, top_row, wr_row;
   logic [6:0] cur_col, wr_col;
   logic       wr_en, busy;
   logic [7:0] wr_char;

   always #5 clk = ~clk;

   term_cursor_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_code  (cmd_code),
      .cmd_p1    (cmd_p1),
      .cmd_p2    (cmd_p2),
      .cur_row   (cur_row),
      .cur_col   (cur_col),
      .top_row   (top_row),
      .wr_en     (wr_en),
      .wr_row    (wr_row),
      .wr_col    (wr_col),
      .wr_char   (wr_char),
      .busy      (busy)
   );

   typedef struct {
      int row;
      int col;
      int top;
      int bsy;
   } done_t;

   done_t cq[$];
   int    wq[$];
   int    nchk = 0;
   int    npass = 0;

   function automatic void chk(string name, int act, int exp);
      nchk++;
      if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else npass++;
   endfunction

   // Expected writes for logical linear range [ls,le] under scroll offset top.
   function automatic void push_fill(int ls, int le, int top);
      for (int i = ls; i <= le; i++)
         wq.push_back((((i / 80) + top) % 25) * 256 + (i % 80));
   endfunction

   // Monitor: check each write and each command completion (busy falling).
   int    bcnt = 0;
   logic  prev_busy = 1'b0;
   int    we;
   done_t de;
   always @(negedge clk) begin
      if (!rst_n) begin
         bcnt      = 0;
         prev_busy = 1'b0;
      end else begin
         if (wr_en) begin
            if (wq.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               we = wq.pop_front();
               chk("wr_row", int'(wr_row), we / 256);
               chk("wr_col", int'(wr_col), we % 256);
               chk("wr_char", int'(wr_char), 32);
            end
         end
         if (busy) begin
            bcnt++;
         end else if (prev_busy) begin
            if (cq.size() == 0) begin
               chk("unexpected_completion", 1, 0);
            end else begin
               de = cq.pop_front();
               chk("cur_row", int'(cur_row), de.row);
               chk("cur_col", int'(cur_col), de.col);
               chk("top_row", int'(top_row), de.top);
               chk("busy_cycles", bcnt, de.bsy);
            end
            bcnt = 0;
         end
         prev_busy = busy;
      end
   end

   // Issue one command; eb < 0 means no completion is expected.
   task automatic issue(input cmd_e c, input int a, input int b,
                        input int er, input int ec, input int et, input int eb);
      done_t d;
      int    t;
      if (eb >= 0) begin
         d.row = er;
         d.col = ec;
         d.top = et;
         d.bsy = eb;
         cq.push_back(d);
      end
      t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) chk("ready_timeout", 0, 1);
      cmd_valid = 1'b1;
      cmd_code  = 4'(c);
      cmd_p1    = 8'(a);
      cmd_p2    = 8'(b);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_cur_row"}, int'(cur_row), 0);
      chk({tag, "_cur_col"}, int'(cur_col), 0);
      chk({tag, "_top_row"}, int'(top_row), 0);
      chk({tag, "_wr_en"}, int'(wr_en), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      #1 chk_reset_state("reset");

      // Cursor moves: busy 1 cycle, 2-cycle accept-to-ready.
      issue(CMD_CUP, 5, 10, 4, 9, 0, 1);
      issue(CMD_CUF, 200, 0, 4, 79, 0, 1);
      issue(CMD_CUB, 0, 0, 4, 78, 0, 1);
      issue(CMD_CUP, 25, 80, 24, 79, 0, 1);
      issue(CMD_CNL, 3, 0, 24, 0, 0, 1);
      issue(CMD_CPL, 0, 0, 23, 0, 0, 1);
      issue(CMD_SCP, 0, 0, 23, 0, 0, 1);
      issue(CMD_CUP, 1, 1, 0, 0, 0, 1);
      issue(CMD_RCP, 0, 0, 23, 0, 0, 1);
      issue(CMD_CUP, 3, 79, 2, 78, 0, 1);

      // EL to end of line at (2,78): two writes.
      push_fill(2 * 80 + 78, 2 * 80 + 79, 0);
      issue(CMD_EL, 0, 0, 2, 78, 0, 3);

      // SD 2 from top 0 -> top 23, fill logical rows 0..1.
      push_fill(0, 159, 23);
      issue(CMD_SD, 2, 0, 2, 78, 23, 161);

      // SU 3 from top 23 -> top 1, logical rows 22..24 = physical 23,24,0.
      push_fill(22 * 80, 1999, 1);
      issue(CMD_SU, 3, 0, 2, 78, 1, 241);

      // ED from screen start to cursor (3,5).
      issue(CMD_CUP, 4, 6, 3, 5, 1, 1);
      push_fill(0, 245, 1);
      issue(CMD_ED, 1, 0, 3, 5, 1, 247);
      issue(CMD_ED, 7, 0, 3, 5, 1, 1);

      // Clear: every cell once, cursor home.
      push_fill(0, 1999, 1);
      issue(CMD_CLEAR, 0, 0, 0, 0, 1, 2001);

      // Clear aborted by reset during the 501st write.
      issue(CMD_CUP, 10, 10, 9, 9, 1, 1);
      push_fill(0, 499, 1);
      issue(CMD_CLEAR, 0, 0, 0, 0, 0, -1);
      repeat (501) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_state("abort");
      chk("abort_wr_row", int'(wr_row), 0);
      chk("abort_wr_col", int'(wr_col), 0);
      chk("abort_writes_left", wq.size(), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Delete at col 0 and mid-line, then no-op and row erase.
      issue(CMD_CUP, 6, 1, 5, 0, 0, 1);
      push_fill(400, 400, 0);
      issue(CMD_DELETE, 0, 0, 5, 0, 0, 2);
      issue(CMD_CUP, 6, 6, 5, 5, 0, 1);
      push_fill(404, 404, 0);
      issue(CMD_DELETE, 0, 0, 5, 4, 0, 2);
      issue(CMD_CHA, 100, 0, 5, 79, 0, 1);
      issue(CMD_NONE, 9, 9, 5, 79, 0, 1);
      issue(CMD_HVP, 0, 0, 0, 0, 0, 1);
      push_fill(0, 79, 0);
      issue(CMD_EL, 2, 0, 0, 0, 0, 81);

      t = 0;
      while ((cq.size() != 0 || wq.size() != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("pending_completions", cq.size(), 0);
      chk("pending_writes", wq.size(), 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
